data_memory_lsu: RTL

//  Load/store unit plus byte-addressed data memory, downstream of the multi-instruction core's execute stage.

---
 rtl/data_memory_lsu_pkg.sv | 29 ++
 rtl/data_memory_lsu_extend.sv | 26 ++
 rtl/data_memory_lsu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Contents: RV32I load/store funct3 codes, FSM state encoding,
// default memory size, and a funct3 legality helper.
package data_memory_lsu_pkg;

  localparam int LSU_MEM_BYTES_DEFAULT = 256;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic lsu_f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      LSU_F3_B, LSU_F3_H, LSU_F3_W: return 1'b1;
      LSU_F3_BU, LSU_F3_HU:         return ~we;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_lsu_extend.sv
// lsu_extend: combinational load-result formatter.
// Ports:
//   raw    in  32  four bytes as read, byte 0 (lowest address) in [7:0]
//   funct3 in  3   RV32I load funct3
//   result out 32  sign/zero-extended load value; 0 for unsupported funct3
module lsu_extend
  import data_memory_lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (funct3)
      LSU_F3_B:  result = {{24{raw[7]}}, raw[7:0]};
      LSU_F3_H:  result = {{16{raw[15]}}, raw[15:0]};
      LSU_F3_W:  result = raw;
      LSU_F3_BU: result = {24'b0, raw[7:0]};
      LSU_F3_HU: result = {16'b0, raw[15:0]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: single-outstanding load/store unit with a byte-addressed,
// little-endian data memory and a programmable response latency.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready in IDLE or RESP)
//   req_we, req_funct3    store flag and RV32I funct3
//   req_addr, req_wdata   byte address (wraps modulo MEM_BYTES), store data
//   resp_valid            one-cycle response pulse
//   resp_rdata            extended load data, 0 for stores/illegal accesses
//   busy                  ~req_ready, core stall
//   resp_fault            only when LSU_MISALIGN_TRAP_EN is defined
// Macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses and illegal funct3 are
// suppressed and reported via resp_fault. Without it misaligned accesses are
// performed byte by byte with address wrap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LSU_IDLE | no request in flight, ready to accept
// LSU_WAIT | request latched, latency counter running down
// LSU_RESP | response cycle (resp_valid=1), may accept the next request
module data_memory_lsu
  import data_memory_lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES_DEFAULT,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        resp_fault
`endif
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [7:0] memory [MEM_BYTES];

  lsu_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       enter_resp;

  logic          lat_we;
  logic [2:0]    lat_f3;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;

  logic          op_we;
  logic [2:0]    op_f3;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_ok;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   raw, ext;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LSU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    enter_resp = 1'b0;
    case (state)
      LSU_IDLE, LSU_RESP: begin
        req_ready  = 1'b1;
        resp_valid = (state == LSU_RESP);
        if (req_valid) begin
          cnt_nxt = CNT_LOAD;
          if (LATENCY == 1) begin
            state_nxt  = LSU_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = LSU_WAIT;
          end
        end else begin
          state_nxt = LSU_IDLE;
        end
      end
      LSU_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = LSU_RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_nxt = LSU_IDLE;
    endcase
  end

  assign busy = ~req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (req_valid && req_ready) begin
      lat_we    <= req_we;
      lat_f3    <= req_funct3;
      lat_addr  <= req_addr[AW-1:0];
      lat_wdata <= req_wdata;
    end
  end

  // With LATENCY=1 the memory is accessed on the accept edge itself, before
  // the request registers hold anything, so the live request is used.
  assign op_we    = (LATENCY == 1) ? req_we            : lat_we;
  assign op_f3    = (LATENCY == 1) ? req_funct3        : lat_f3;
  assign op_addr  = (LATENCY == 1) ? req_addr[AW-1:0]  : lat_addr;
  assign op_wdata = (LATENCY == 1) ? req_wdata         : lat_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
  logic op_misalign;
  assign op_misalign = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                       ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
  assign op_ok = lsu_f3_legal(op_we, op_f3) && !op_misalign;
`else
  assign op_ok = lsu_f3_legal(op_we, op_f3);
`endif

  // Byte lanes wrap naturally in AW-bit arithmetic.
  assign a0  = op_addr;
  assign a1  = op_addr + AW'(1);
  assign a2  = op_addr + AW'(2);
  assign a3  = op_addr + AW'(3);
  assign raw = {memory[a3], memory[a2], memory[a1], memory[a0]};

  lsu_extend u_extend (
    .raw    (raw),
    .funct3 (op_f3),
    .result (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_fault <= 1'b0;
`endif
    end else if (enter_resp) begin
      resp_rdata <= (op_we || !op_ok) ? 32'b0 : ext;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_fault <= !op_ok;
`endif
    end
  end

  // Memory is not reset; reset only blocks a commit on the edge it is sampled.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_we && op_ok) begin
      memory[a0] <= op_wdata[7:0];
      if (op_f3 != LSU_F3_B) memory[a1] <= op_wdata[15:8];
      if (op_f3 == LSU_F3_W) begin
        memory[a2] <= op_wdata[23:16];
        memory[a3] <= op_wdata[31:24];
      end
    end
  end

endmodule
